mc_cpu: RTL and testbench

Multi-cycle MIPS-subset processor core: the parametrised successor to the single-cycle datapath. One shared memory port with a req/ready handshake carries both instruction fetch and data access. A five-state control FSM sequences each instruction over 3–5 cycles. The register file, ALU, sign extension and next-PC logic are internal, and the core stalls on any memory wait state.

---
 rtl/mc_cpu.sv | 270 +++++++++++++++++++++++++++
 tb/tb_mc_cpu.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_cpu.sv
// rtl/mc_cpu.sv - multi-cycle MIPS-subset core with one shared memory port
//
// Purpose: fetches and executes add/sub/and/or/slt, addi, lw, sw, beq, j and
// halt over a FETCH/DECODE/EXEC/MEM/WB state sequence. Instruction fetch and
// data access share one req/ready memory port; any wait state stalls the FSM.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   mem_req    memory transaction request
//   mem_we     1 = store, 0 = load/fetch (valid while mem_req)
//   mem_addr   word-aligned byte address
//   mem_wdata  store data
//   mem_rdata  read data, valid while mem_ready
//   mem_ready  transaction completes this cycle
//   pc_out     current PC
//   retire     one-cycle pulse per completed instruction
//   halted     sticky, core stopped
//   illegal    sticky, halt caused by an undefined op/funct
module mc_cpu #(
  parameter int          NREG     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_out,
  output logic        retire,
  output logic        halted,
  output logic        illegal
);

  localparam int RW = $clog2(NREG);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] t_q, t_d;
  logic [31:0] y_q, y_d;
  logic [31:0] m_q, m_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;

  logic [31:0] rf_q [NREG];

  // Instruction fields, always taken from the latched IR.
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  // The shamt field has no meaning in this subset.
  logic unused_shamt;
  assign unused_shamt = ^ir_q[10:6];

  // Register fields use only the low log2(NREG) bits.
  logic [RW-1:0] rs_idx, rt_idx, wr_idx;
  logic [31:0]   rs_val, rt_val, wr_data;
  logic          rf_we;

  assign rs_idx  = rs[RW-1:0];
  assign rt_idx  = rt[RW-1:0];
  assign wr_idx  = (op == OP_RTYPE) ? rd[RW-1:0] : rt[RW-1:0];
  assign wr_data = (op == OP_LW) ? m_q : y_q;
  assign rs_val  = (rs_idx == '0) ? 32'h0 : rf_q[rs_idx];
  assign rt_val  = (rt_idx == '0) ? 32'h0 : rf_q[rt_idx];

  // Opcode / funct legality.
  logic funct_ok, op_ok;
  always_comb begin
    funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    case (op)
      OP_RTYPE: op_ok = funct_ok;
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT: op_ok = 1'b1;
      default:  op_ok = 1'b0;
    endcase
  end

  // R-type ALU.
  logic [31:0] alu_y;
  always_comb begin
    case (funct)
      FN_ADD:  alu_y = a_q + b_q;
      FN_SUB:  alu_y = a_q - b_q;
      FN_AND:  alu_y = a_q & b_q;
      FN_OR:   alu_y = a_q | b_q;
      FN_SLT:  alu_y = {31'h0, $signed(a_q) < $signed(b_q)};
      default: alu_y = 32'h0;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    t_d       = t_q;
    y_d       = y_q;
    m_d       = m_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = b_q;
    retire    = 1'b0;
    rf_we     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = rs_val;
        b_d = rt_val;
        // Branch target from the already-incremented PC.
        t_d = pc_q + {imm_sext[29:0], 2'b00};
        if (op == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (!op_ok) begin
          halted_d  = 1'b1;
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op)
          OP_RTYPE: begin
            y_d     = alu_y;
            state_d = S_WB;
          end
          OP_ADDI: begin
            y_d     = a_q + imm_sext;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            y_d     = a_q + imm_sext;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = t_q;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_J: begin
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (op == OP_SW);
        mem_addr = {y_q[31:2], 2'b00};
        if (mem_ready) begin
          if (op == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            m_d     = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset kills any transaction and side effect of the current cycle.
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      retire  = 1'b0;
      rf_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      t_q       <= 32'h0;
      y_q       <= 32'h0;
      m_q       <= 32'h0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      t_q       <= t_d;
      y_q       <= y_d;
      m_q       <= m_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Register file has no reset; r0 is never written.
  always_ff @(posedge clk) begin
    if (rf_we && (wr_idx != '0)) rf_q[wr_idx] <= wr_data;
  end

  assign pc_out  = pc_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_cpu.sv
// tb/tb_mc_cpu.sv - self-checking bench for mc_cpu
module tb_mc_cpu;

  localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, halted, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

  logic        rst8 = 1'b1;
  logic        m8_req, m8_we, m8_ready, retire8, halted8, illegal8;
  logic [31:0] m8_addr, m8_wdata, m8_rdata, pc8;

  mc_cpu #(.NREG(32), .RESET_PC(32'h100)) u_dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc_out(pc_out), .retire(retire),
    .halted(halted), .illegal(illegal)
  );

  mc_cpu #(.NREG(8), .RESET_PC(32'h100)) u_dut8 (
    .clk(clk), .rst(rst8), .mem_req(m8_req), .mem_we(m8_we),
    .mem_addr(m8_addr), .mem_wdata(m8_wdata), .mem_rdata(m8_rdata),
    .mem_ready(m8_ready), .pc_out(pc8), .retire(retire8),
    .halted(halted8), .illegal(illegal8)
  );

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: code and data live in separate arrays, selected by address.
  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic [31:0] imem8 [256];
  int ws_fetch = 0;
  int ws_data = 0;
  int wcnt = 0;
  int cyc = 0;

  function automatic bit is_data(input logic [31:0] a);
    return (a < 32'h40) || (a >= 32'h80 && a < 32'h100);
  endfunction

  assign mem_ready = mem_req && (wcnt >= (is_data(mem_addr) ? ws_data : ws_fetch));
  assign mem_rdata = is_data(mem_addr) ? dmem[mem_addr[9:2]] : imem[mem_addr[9:2]];
  assign m8_ready  = m8_req;
  assign m8_rdata  = imem8[m8_addr[9:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mem_req && mem_we && mem_ready) dmem[mem_addr[9:2]] <= mem_wdata;
  end

  // Store scoreboard: expected stores queued by the test, checked on completion.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          hold;
  } st_t;
  st_t sb_q[$];
  int  retire_cyc[$];
  int  hold_cnt = 0;
  bit  h_stable = 1'b1;
  logic [31:0] h_addr, h_data;

  always @(negedge clk) begin
    st_t e;
    if (retire) retire_cyc.push_back(cyc);
    if (mem_req && mem_we) begin
      if (hold_cnt == 0) begin
        h_addr   = mem_addr;
        h_data   = mem_wdata;
        h_stable = 1'b1;
      end else if (mem_addr !== h_addr || mem_wdata !== h_data) begin
        h_stable = 1'b0;
      end
      hold_cnt++;
      if (mem_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL store_unexpected: got addr 0x%08h data 0x%08h, expected none", mem_addr, mem_wdata);
        end else begin
          e = sb_q.pop_front();
          chk("store_addr", mem_addr, e.addr);
          chk("store_data", mem_wdata, e.data);
          if (e.hold > 0) begin
            chk("store_hold_cycles", hold_cnt, e.hold);
            chk("store_stable", {31'h0, h_stable}, 32'h1);
          end
        end
        hold_cnt = 0;
      end
    end else begin
      hold_cnt = 0;
    end
  end

  int st8_cnt = 0;
  logic [31:0] st8_addr = '0, st8_data = '0, st8_first = '0;
  always @(negedge clk) begin
    if (m8_req && m8_we && m8_ready) begin
      if (st8_cnt == 0) st8_first = m8_wdata;
      st8_cnt++;
      st8_addr = m8_addr;
      st8_data = m8_wdata;
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] target);
    return {OP_J, target[27:2]};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    imem[addr[9:2]] = w;
  endtask

  task automatic expect_st(input logic [31:0] a, input logic [31:0] d, input int h);
    st_t e;
    e.addr = a;
    e.data = d;
    e.hold = h;
    sb_q.push_back(e);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_to_halt(input int max);
    int k = 0;
    while (!halted && k < max) begin
      @(negedge clk);
      k++;
    end
    chk("halt_reached", {31'h0, halted}, 32'h1);
  endtask

  task automatic wait_retire(input int max, output int c);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!retire && k < max);
    chk("retire_seen", {31'h0, retire}, 32'h1);
    c = cyc;
  endtask

  typedef struct {
    logic [5:0]  funct;
    logic [15:0] ia;
    logic [15:0] ib;
    logic [31:0] exp;
    int          wsf;
  } vec_t;
  vec_t vecs[11];

  initial begin
    int base, c0, c1, nreq, k;
    bit found;

    vecs[0]  = '{FN_ADD, 16'h0005, 16'hFFF9, 32'hFFFF_FFFE, 0};
    vecs[1]  = '{FN_SUB, 16'h0005, 16'hFFF9, 32'h0000_000C, 1};
    vecs[2]  = '{FN_AND, 16'h7F0F, 16'h00FF, 32'h0000_000F, 0};
    vecs[3]  = '{FN_OR,  16'h7000, 16'h000F, 32'h0000_700F, 2};
    vecs[4]  = '{FN_SLT, 16'hFFF9, 16'h0005, 32'h0000_0001, 0};
    vecs[5]  = '{FN_SLT, 16'h0005, 16'hFFF9, 32'h0000_0000, 0};
    vecs[6]  = '{FN_SLT, 16'h0005, 16'h0005, 32'h0000_0000, 1};
    vecs[7]  = '{FN_ADD, 16'h7FFF, 16'h7FFF, 32'h0000_FFFE, 0};
    vecs[8]  = '{FN_SUB, 16'h8000, 16'h0001, 32'hFFFF_7FFF, 0};
    vecs[9]  = '{FN_AND, 16'hFFFF, 16'h8000, 32'hFFFF_8000, 0};
    vecs[10] = '{FN_SUB, 16'h0003, 16'h0005, 32'hFFFF_FFFE, 0};

    for (int i = 0; i < 256; i++) begin
      imem[i]  = HALT_W;
      imem8[i] = HALT_W;
    end

    // Reset and first fetch.
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_mem_req", {31'h0, mem_req}, 32'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("first_fetch_req", {31'h0, mem_req}, 32'h1);
    chk("first_fetch_addr", mem_addr, 32'h100);
    chk("first_fetch_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    chk("pc_after_fetch", pc_out, 32'h104);
    run_to_halt(20);
    chk("halt_not_illegal", {31'h0, illegal}, 32'h0);

    // ALU sequence, zero wait states.
    put(32'h100, enc_i(OP_ADDI, 0, 1, 16'h0005));
    put(32'h104, enc_i(OP_ADDI, 0, 2, 16'hFFF9));
    put(32'h108, enc_r(1, 2, 3, FN_ADD));
    put(32'h10C, enc_r(2, 1, 4, FN_SLT));
    put(32'h110, enc_r(0, 1, 5, FN_SUB));
    put(32'h114, enc_i(OP_SW, 0, 3, 16'h0080));
    put(32'h118, enc_i(OP_SW, 0, 4, 16'h0084));
    put(32'h11C, enc_i(OP_SW, 0, 5, 16'h0088));
    put(32'h120, HALT_W);
    expect_st(32'h80, 32'hFFFF_FFFE, 1);
    expect_st(32'h84, 32'h1, 1);
    expect_st(32'h88, 32'hFFFF_FFFB, 1);
    apply_reset(2);
    base = retire_cyc.size();
    repeat (20) @(negedge clk);
    #1 chk("alu_retires_in_20", retire_cyc.size() - base, 5);
    run_to_halt(100);
    chk("alu_sb_drained", sb_q.size(), 0);

    // Table of R-type vectors, some with fetch wait states.
    for (int i = 0; i < 11; i++) begin
      put(32'h100, enc_i(OP_ADDI, 0, 1, vecs[i].ia));
      put(32'h104, enc_i(OP_ADDI, 0, 2, vecs[i].ib));
      put(32'h108, enc_r(1, 2, 3, vecs[i].funct));
      put(32'h10C, enc_i(OP_SW, 0, 3, 16'h008C));
      put(32'h110, HALT_W);
      expect_st(32'h8C, vecs[i].exp, 0);
      ws_fetch = vecs[i].wsf;
      apply_reset(2);
      base = retire_cyc.size();
      run_to_halt(200);
      chk("vec_sb_drained", sb_q.size(), 0);
      if (retire_cyc.size() >= base + 3)
        chk("vec_rtype_cycles", retire_cyc[base+2] - retire_cyc[base+1], 4 + vecs[i].wsf);
      else
        chk("vec_retire_count", retire_cyc.size() - base, 4);
    end
    ws_fetch = 0;

    // Load/store with two data wait states.
    put(32'h100, enc_i(OP_ADDI, 0, 1, 16'h0005));
    put(32'h104, enc_i(OP_SW, 0, 1, 16'h0008));
    put(32'h108, enc_i(OP_LW, 0, 6, 16'h0008));
    put(32'h10C, enc_i(OP_SW, 0, 6, 16'h0080));
    put(32'h110, HALT_W);
    expect_st(32'h8, 32'h5, 3);
    expect_st(32'h80, 32'h5, 3);
    ws_data = 2;
    apply_reset(2);
    base = retire_cyc.size();
    run_to_halt(200);
    chk("ls_sb_drained", sb_q.size(), 0);
    if (retire_cyc.size() >= base + 3) begin
      chk("sw_cycles", retire_cyc[base+1] - retire_cyc[base], 6);
      chk("lw_cycles", retire_cyc[base+2] - retire_cyc[base+1], 7);
    end else begin
      chk("ls_retire_count", retire_cyc.size() - base, 4);
    end
    ws_data = 0;

    // Branch self-loop twice, then patched into a jump to 0x40.
    put(32'h100, enc_i(OP_ADDI, 0, 1, 16'h0001));
    put(32'h104, enc_i(OP_BEQ, 1, 1, 16'hFFFF));
    put(32'h40, enc_i(OP_SW, 0, 1, 16'h0080));
    put(32'h44, HALT_W);
    expect_st(32'h80, 32'h1, 0);
    apply_reset(2);
    wait_retire(20, c0);
    wait_retire(20, c0);
    @(negedge clk);
    chk("beq_pc_1", pc_out, 32'h104);
    wait_retire(20, c1);
    chk("beq_loop_cycles", c1 - c0, 3);
    @(negedge clk);
    chk("beq_pc_2", pc_out, 32'h104);
    put(32'h104, enc_j(32'h40));
    wait_retire(20, c0);
    @(negedge clk);
    chk("jump_fetch_req", {31'h0, mem_req}, 32'h1);
    chk("jump_fetch_addr", mem_addr, 32'h40);
    run_to_halt(50);
    chk("jump_sb_drained", sb_q.size(), 0);
    chk("jump_halt_pc", pc_out, 32'h48);

    // Halt, then illegal funct, then illegal opcode.
    put(32'h100, HALT_W);
    apply_reset(2);
    run_to_halt(20);
    chk("halt_illegal_flag", {31'h0, illegal}, 32'h0);
    chk("halt_pc_frozen", pc_out, 32'h104);
    nreq = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_req) nreq++;
    end
    chk("halt_no_req", nreq, 0);
    put(32'h100, enc_r(0, 0, 0, 6'h3F));
    apply_reset(1);
    chk("rst_clears_halted", {31'h0, halted}, 32'h0);
    run_to_halt(20);
    chk("ill_funct_flag", {31'h0, illegal}, 32'h1);
    nreq = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_req) nreq++;
    end
    chk("ill_no_req", nreq, 0);
    put(32'h100, {6'h10, 26'h0});
    apply_reset(1);
    chk("rst_clears_illegal", {31'h0, illegal}, 32'h0);
    run_to_halt(20);
    chk("ill_op_flag", {31'h0, illegal}, 32'h1);

    // Reset during a stalled lw; then r0 and not-taken beq.
    put(32'h100, enc_i(OP_ADDI, 0, 6, 16'h0003));
    put(32'h104, enc_i(OP_LW, 0, 6, 16'h0008));
    put(32'h108, HALT_W);
    ws_data = 20;
    apply_reset(2);
    found = 1'b0;
    k = 0;
    while (!found && k < 40) begin
      @(negedge clk);
      k++;
      if (mem_req && !mem_we && mem_addr == 32'h8) found = 1'b1;
    end
    chk("midrst_lw_seen", {31'h0, found}, 32'h1);
    repeat (2) @(negedge clk);
    chk("midrst_stalled", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    ws_data = 0;
    put(32'h100, enc_i(OP_SW, 0, 6, 16'h0080));
    put(32'h104, enc_i(OP_ADDI, 0, 0, 16'h0009));
    put(32'h108, enc_i(OP_SW, 0, 0, 16'h0084));
    put(32'h10C, enc_i(OP_ADDI, 0, 1, 16'h0004));
    put(32'h110, enc_i(OP_BEQ, 1, 0, 16'h0001));
    put(32'h114, enc_i(OP_SW, 0, 1, 16'h0088));
    put(32'h118, HALT_W);
    expect_st(32'h80, 32'h3, 0);
    expect_st(32'h84, 32'h0, 0);
    expect_st(32'h88, 32'h4, 0);
    #1 chk("midrst_req_drop", {31'h0, mem_req}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_to_halt(100);
    chk("midrst_sb_drained", sb_q.size(), 0);

    // NREG=8 instance: rd/rt field 9 and 17 alias r1.
    imem8[32'h100 >> 2] = enc_i(OP_ADDI, 0, 2, 16'h0007);
    imem8[32'h104 >> 2] = enc_r(2, 0, 9, FN_ADD);
    imem8[32'h108 >> 2] = enc_i(OP_SW, 0, 1, 16'h0080);
    imem8[32'h10C >> 2] = enc_i(OP_SW, 0, 17, 16'h0084);
    imem8[32'h110 >> 2] = HALT_W;
    @(posedge clk);
    #1 rst8 = 1'b0;
    k = 0;
    while (!halted8 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("n8_halted", {31'h0, halted8}, 32'h1);
    chk("n8_store_count", st8_cnt, 2);
    chk("n8_first_data", st8_first, 32'h7);
    chk("n8_last_addr", st8_addr, 32'h84);
    chk("n8_last_data", st8_data, 32'h7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
